// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA controller: pattern modes and the colour-bar table.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_BLACK  = 2'd0,
    MODE_GRID   = 2'd1,
    MODE_BARS   = 2'd2,
    MODE_STREAM = 2'd3
  } mode_e;

  // Entry 0 is the leftmost bar.
  localparam logic [7:0][23:0] BAR_COLORS = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

endpackage

// File: rtl/video_if.sv
// Parallel RGB video bundle with syncs and blank; the master drives all signals.
interface video_if;
  logic        CLK;
  logic [23:0] RGB;
  logic        HS;
  logic        VS;
  logic        BLANK;

  modport master (output CLK, RGB, HS, VS, BLANK);
  modport slave  (input  CLK, RGB, HS, VS, BLANK);
endinterface

// File: rtl/vga_timing.sv
// Pixel/line counters with combinational active and sync decode; zero latency from counter state.
// Free-running, no backpressure.
module vga_timing #(
  parameter int HDISP  = 800,
  parameter int VDISP  = 480,
  parameter int HFP    = 40,
  parameter int HPULSE = 48,
  parameter int HBP    = 40,
  parameter int VFP    = 13,
  parameter int VPULSE = 3,
  parameter int VBP    = 29,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  localparam int HTOT  = HFP + HPULSE + HBP + HDISP,
  localparam int VTOT  = VFP + VPULSE + VBP + VDISP,
  localparam int HW    = $clog2(HTOT),
  localparam int VW    = $clog2(VTOT)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic [HW-1:0] pixel_cpt_o,
  output logic [VW-1:0] line_cpt_o,
  output logic          active_o,
  output logic          hs_o,
  output logic          vs_o
);

  localparam logic [HW-1:0] HLAST  = HW'(HTOT - 1);
  localparam logic [HW-1:0] HSTART = HW'(HTOT - HDISP);
  localparam logic [HW-1:0] HS_BEG = HW'(HFP);
  localparam logic [HW-1:0] HS_END = HW'(HFP + HPULSE);
  localparam logic [VW-1:0] VLAST  = VW'(VTOT - 1);
  localparam logic [VW-1:0] VSTART = VW'(VTOT - VDISP);
  localparam logic [VW-1:0] VS_BEG = VW'(VFP);
  localparam logic [VW-1:0] VS_END = VW'(VFP + VPULSE);

  logic [HW-1:0] pixel_q, pixel_d;
  logic [VW-1:0] line_q, line_d;

  always_comb begin
    pixel_d = pixel_q + 1'b1;
    line_d  = line_q;
    if (pixel_q == HLAST) begin
      pixel_d = '0;
      line_d  = (line_q == VLAST) ? '0 : line_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pixel_q <= '0;
      line_q  <= '0;
    end else begin
      pixel_q <= pixel_d;
      line_q  <= line_d;
    end
  end

  assign pixel_cpt_o = pixel_q;
  assign line_cpt_o  = line_q;
  assign active_o    = (pixel_q >= HSTART) && (line_q >= VSTART);
  assign hs_o        = (pixel_q >= HS_BEG && pixel_q < HS_END) ? HS_POL : ~HS_POL;
  assign vs_o        = (line_q >= VS_BEG && line_q < VS_END) ? VS_POL : ~VS_POL;

endmodule

// File: rtl/vga_ctrl.sv
// VGA controller: test patterns or a pixel stream onto registered video outputs, 1 cycle after the counters.
// Stream source is pulled with pix_ready during active video; a missing pixel is painted black and flagged.
module vga_ctrl
  import vga_pkg::*;
#(
  parameter int HDISP  = 800,
  parameter int VDISP  = 480,
  parameter int HFP    = 40,
  parameter int HPULSE = 48,
  parameter int HBP    = 40,
  parameter int VFP    = 13,
  parameter int VPULSE = 3,
  parameter int VBP    = 29,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst,
  input  logic [1:0]  mode,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        sof,
  output logic        underflow,
  input  logic        underflow_clr,
  video_if.master     video_ifm
);

  localparam int HTOT = HFP + HPULSE + HBP + HDISP;
  localparam int VTOT = VFP + VPULSE + VBP + VDISP;
  localparam int HW   = $clog2(HTOT);
  localparam int VW   = $clog2(VTOT);
  localparam logic [HW-1:0] HSTART   = HW'(HTOT - HDISP);
  localparam logic [HW-1:0] HPRE     = HW'(HTOT - HDISP - 1);
  localparam logic [HW-1:0] BAR_LAST = HW'(HDISP / 8 - 1);
  localparam logic [VW-1:0] VSTART   = VW'(VTOT - VDISP);

  if (HDISP % 8 != 0) begin : g_hdisp_chk
    $error("vga_ctrl: HDISP must be a multiple of 8");
  end

  logic [HW-1:0] pixel_cpt;
  logic [VW-1:0] line_cpt;
  logic          active, hs, vs, frame_start, stream_miss;
  logic [3:0]    hx4, vy4;
  mode_e         mode_q, mode_d;
  logic [HW-1:0] bar_px_q, bar_px_d;
  logic [2:0]    bar_idx_q, bar_idx_d;
  logic [23:0]   rgb_q, rgb_d;
  logic          hs_q, vs_q, blank_q, sof_q, underflow_q, underflow_d;

  vga_timing #(
    .HDISP(HDISP), .VDISP(VDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
    .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP), .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) u_timing (
    .clk_i       (pixel_clk),
    .rst_i       (pixel_rst),
    .pixel_cpt_o (pixel_cpt),
    .line_cpt_o  (line_cpt),
    .active_o    (active),
    .hs_o        (hs),
    .vs_o        (vs)
  );

  assign frame_start = (pixel_cpt == '0) && (line_cpt == '0);
  // Only the low nibble of the offset matters for the 16-pixel grid.
  assign hx4         = pixel_cpt[3:0] - HSTART[3:0];
  assign vy4         = line_cpt[3:0] - VSTART[3:0];
  assign pix_ready   = !pixel_rst && (mode_q == MODE_STREAM) && active;
  assign stream_miss = (mode_q == MODE_STREAM) && active && !pix_valid;

  always_comb begin
    mode_d = mode_q;
    if (frame_start) mode_d = mode_e'(mode);

    // Bar position is tracked per pixel and restarted just before each line's active region.
    bar_px_d  = bar_px_q;
    bar_idx_d = bar_idx_q;
    if (pixel_cpt == HPRE) begin
      bar_px_d  = '0;
      bar_idx_d = '0;
    end else if (pixel_cpt >= HSTART) begin
      if (bar_px_q == BAR_LAST) begin
        bar_px_d  = '0;
        bar_idx_d = bar_idx_q + 1'b1;
      end else begin
        bar_px_d = bar_px_q + 1'b1;
      end
    end

    rgb_d = '0;
    if (active) begin
      case (mode_q)
        MODE_GRID:   rgb_d = (hx4 == 4'd0 || vy4 == 4'd0) ? 24'hFFFFFF : 24'h000000;
        MODE_BARS:   rgb_d = BAR_COLORS[bar_idx_q];
        MODE_STREAM: rgb_d = pix_valid ? pix_data : 24'h000000;
        default:     rgb_d = '0;
      endcase
    end

    underflow_d = underflow_q;
    if (underflow_clr) underflow_d = 1'b0;
    if (stream_miss)   underflow_d = 1'b1;
  end

  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      mode_q      <= MODE_BLACK;
      bar_px_q    <= '0;
      bar_idx_q   <= '0;
      rgb_q       <= '0;
      hs_q        <= ~HS_POL;
      vs_q        <= ~VS_POL;
      blank_q     <= 1'b0;
      sof_q       <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      bar_px_q    <= bar_px_d;
      bar_idx_q   <= bar_idx_d;
      rgb_q       <= rgb_d;
      hs_q        <= hs;
      vs_q        <= vs;
      blank_q     <= active;
      sof_q       <= frame_start;
      underflow_q <= underflow_d;
    end
  end

  assign video_ifm.CLK   = pixel_clk;
  assign video_ifm.RGB   = rgb_q;
  assign video_ifm.HS    = hs_q;
  assign video_ifm.VS    = vs_q;
  assign video_ifm.BLANK = blank_q;
  assign sof             = sof_q;
  assign underflow       = underflow_q;

endmodule
